// File: rtl/piso_pkg.sv
// piso_tx shared definitions: state encoding and default word width.
// Imported by the transmitter top.
package piso_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam int DEF_WIDTH = 4;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_t;

endpackage

// File: rtl/piso_tx.sv
// piso_tx: loads a WIDTH-bit word on a valid/ready handshake, shifts it MSB first.
// Ports: clk, rst (async low), din/load_valid/load_ready in, s_out/s_valid/s_last out.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);

  state_t          state;
  state_t          state_n;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic            at_last;
  logic            accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
    end
  end

  // A load on the final bit wins over the return to IDLE,
  // so words stream without a gap.
  always_comb begin
    at_last    = (cnt == CLAST);
    s_valid    = (state == SHIFT);
    s_last     = s_valid && at_last;
    load_ready = !s_valid || at_last;
    s_out      = sreg[WIDTH-1];
    accept     = load_valid && load_ready;

    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;

    if (accept) begin
      state_n = SHIFT;
      sreg_n  = din;
      cnt_n   = '0;
    end else if (s_last) begin
      state_n = IDLE;
      sreg_n  = '0;
      cnt_n   = '0;
    end else if (s_valid) begin
      sreg_n = {sreg[WIDTH-2:0], 1'b0};
      cnt_n  = cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx at WIDTH 4 and 8.
// Expected bits are queued on accept and popped by a negedge monitor.
module tb_piso_tx;

  logic       clk;
  logic       rst;
  logic       lv [2];
  logic [7:0] dn [2];
  logic       rdy [2];
  logic       so [2];
  logic       sv [2];
  logic       sl [2];

  logic [1:0] eq [2][$];
  logic [7:0] wq [2][$];
  logic [7:0] rx [2];

  int tests = 0;
  int fails = 0;

  piso_tx #(.WIDTH(4)) u4 (
    .clk        (clk),
    .rst        (rst),
    .din        (dn[0][3:0]),
    .load_valid (lv[0]),
    .load_ready (rdy[0]),
    .s_out      (so[0]),
    .s_valid    (sv[0]),
    .s_last     (sl[0])
  );

  piso_tx #(.WIDTH(8)) u8 (
    .clk        (clk),
    .rst        (rst),
    .din        (dn[1]),
    .load_valid (lv[1]),
    .load_ready (rdy[1]),
    .s_out      (so[1]),
    .s_valid    (sv[1]),
    .s_last     (sl[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(input int j);
    return (j == 0) ? 4 : 8;
  endfunction

  function automatic logic [7:0] msk(input int j);
    return (j == 0) ? 8'h0F : 8'hFF;
  endfunction

  task automatic chk(input string nm, input int j,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s w%0d: got %0h expected %0h at %0t",
               nm, wid(j), act, exp, $time);
    end
  endtask

  // Reference: an accepted word becomes WIDTH bits, MSB first,
  // flagged last on din[0]. A new word is taken only once the
  // previous one is down to its final bit (queue empty here).
  always @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 2; j++) begin
        if (lv[j] && eq[j].size() == 0) begin
          for (int i = 0; i < wid(j); i++)
            eq[j].push_back({dn[j][wid(j)-1-i], i == wid(j) - 1});
          wq[j].push_back(dn[j] & msk(j));
        end
      end
    end
  end

  always @(negedge rst) begin
    for (int j = 0; j < 2; j++) begin
      eq[j].delete();
      wq[j].delete();
    end
  end

  task automatic mon(input int j);
    logic [1:0] e;
    if (!rst) begin
      chk("rst_ready", j, rdy[j], 1);
      chk("rst_valid", j, sv[j], 0);
      chk("rst_out", j, so[j], 0);
      chk("rst_last", j, sl[j], 0);
      return;
    end
    chk("ready", j, rdy[j], eq[j].size() <= 1);
    if (eq[j].size() == 0) begin
      chk("idle_valid", j, sv[j], 0);
      chk("idle_out", j, so[j], 0);
      chk("idle_last", j, sl[j], 0);
    end else begin
      e = eq[j].pop_front();
      chk("valid", j, sv[j], 1);
      chk("bit", j, so[j], e[1]);
      chk("last", j, sl[j], e[0]);
    end
    if (sv[j] === 1'b1)
      rx[j] = ((rx[j] << 1) | {7'd0, so[j]}) & msk(j);
    if (sv[j] === 1'b1 && sl[j] === 1'b1) begin
      if (wq[j].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_extra w%0d: got word %0h expected none",
                 wid(j), rx[j]);
      end else begin
        chk("rx_word", j, rx[j], wq[j].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int j, input logic [7:0] d);
    lv[j] = 1'b1;
    dn[j] = d;
    cyc(1);
    lv[j] = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    rx[0] = '0;
    rx[1] = '0;
    for (int j = 0; j < 2; j++) begin
      lv[j] = 1'b0;
      dn[j] = '0;
    end
    cyc(3);
    rst = 1'b1;
    cyc(10);

    send(0, 8'h0B);
    cyc(6);

    lv[0] = 1'b1;
    dn[0] = 8'h0A;
    cyc(1);
    dn[0] = 8'h05;
    cyc(4);
    lv[0] = 1'b0;
    cyc(6);

    send(0, 8'h0B);
    cyc(1);
    lv[0] = 1'b1;
    dn[0] = 8'h0F;
    cyc(1);
    lv[0] = 1'b0;
    cyc(6);

    send(1, 8'hC3);
    cyc(10);

    send(0, 8'h0B);
    cyc(2);
    #2;
    rst = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) begin
      chk("async_rst_valid", j, sv[j], 0);
      chk("async_rst_out", j, so[j], 0);
      chk("async_rst_ready", j, rdy[j], 1);
    end
    cyc(2);
    rst = 1'b1;
    send(1, 8'h5A);
    cyc(10);

    repeat (400) begin
      for (int j = 0; j < 2; j++) begin
        lv[j] = ($urandom_range(0, 3) != 0);
        dn[j] = 8'($urandom);
      end
      cyc(1);
    end
    lv[0] = 1'b0;
    lv[1] = 1'b0;
    cyc(12);
    for (int j = 0; j < 2; j++)
      chk("drain", j, eq[j].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter that loads a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, MSB first. It is the transmit end of the design's serial-in shift-register path. A receiver that shifts into bit 0 each clock holds the original word after WIDTH valid cycles. Back-to-back loads are supported, so consecutive words stream with no idle gap.

## Interface
Parameters:
- WIDTH, 4: word length in bits; legal range ≥ 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- din  in  WIDTH  parallel word; sampled only on an accepted load.
- load_valid  in  1  source has a word on din.
- load_ready  out  1  transmitter can accept a word this cycle.
- s_out  out  1  serial data bit.
- s_valid  out  1  s_out carries a valid bit this cycle.
- s_last  out  1  current s_out is bit 0 of the word, the final bit.

## Operation
- One clock domain. Reset is asynchronous and active-low.
- Internal state:
  - FSM with states IDLE and SHIFT.
  - shift register sreg[WIDTH-1:0].
  - bit counter cnt of width $clog2(WIDTH), counting 0..WIDTH-1.
- Accept condition: load_valid && load_ready at a rising edge.
- load_ready is combinational: 1 in IDLE; 1 in SHIFT when cnt == WIDTH-1; 0 otherwise.
- On accept: sreg ← din, cnt ← 0, state ← SHIFT.
- In SHIFT without accept:
  - while cnt < WIDTH-1: sreg ← {sreg[WIDTH-2:0], 1'b0}, cnt ← cnt+1.
  - at cnt == WIDTH-1: state ← IDLE, sreg ← 0, cnt ← 0.
- Outputs:
  - s_out = sreg[WIDTH-1].
  - s_valid = (state == SHIFT).
  - s_last = s_valid && (cnt == WIDTH-1).
- Bit order: din[WIDTH-1] goes out first and din[0] last. A receiver that shifts s_out into q[0] on each s_valid clock holds q == din after the word.
- Simultaneous last bit and new load: the accept wins. The next word's MSB appears on the following cycle and s_valid stays high.
- load_valid while load_ready = 0: ignored; din is not sampled and no state changes.
- IDLE: s_out = 0, s_valid = 0, s_last = 0.

## Timing
- Reset (rst = 0, any time, including mid-word):
  - immediately state = IDLE, sreg = 0, cnt = 0.
  - s_out = 0, s_valid = 0, s_last = 0, load_ready = 1.
  - a partially sent word is discarded.
- Latency: load accepted at edge k → din[WIDTH-1] on s_out in cycle k+1.
- A word occupies exactly WIDTH consecutive s_valid cycles, k+1 .. k+WIDTH.
- s_last is high in cycle k+WIDTH only.
- Throughput: one word per WIDTH cycles with continuous load_valid; s_valid never drops between words.
- First accept after reset release is possible on the first rising edge with rst = 1.

## Structure
- Shared package/header piso_pkg: state encoding localparams ST_IDLE = 1'b0 and ST_SHIFT = 1'b1, and the default WIDTH.
- Sub-module: none required. The single-bit flip-flop cell is not reused, because sreg needs a parallel-load mux.
- RTL organisation:
  - one sequential block for state, sreg and cnt with async reset.
  - one combinational block for load_ready, s_valid and s_last.

## Test plan
- Reset: assert rst = 0 mid-word, three cycles after a load of 4'b1011 → same cycle s_valid = 0, s_out = 0, load_ready = 1; no further bits after release.
- Single word, WIDTH = 4, din = 4'b1011 accepted at edge k → s_out = 1, 0, 1, 1 in cycles k+1..k+4; s_last only in k+4; a bench 4-bit serial-in receiver then reads 4'b1011.
- Back-to-back: load_valid held high, din = 4'hA then 4'h5 → second accept coincides with s_last of the first word; 8 contiguous s_valid cycles with s_out = 1,0,1,0,0,1,0,1.
- Blocked load: pulse load_valid with din = 4'hF during the second bit of a word → ignored; the current word is unchanged and no extra word is sent.
- Parameter sweep WIDTH = 8, din = 8'hC3 → s_out = 1,1,0,0,0,0,1,1; s_last on the 8th bit; load_ready low on bits 1–7.
- Idle hold: load_valid = 0 for 10 cycles after reset → s_valid = 0, s_out = 0, load_ready = 1 throughout.
